// File: rtl/updown_counter_param_if.sv
// Control and status bundle for the parametrised up/down counter.
// Latency: none, signal grouping only.
// Backpressure: none; the counter accepts a command every cycle.
interface updown_counter_param_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             up_dn;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] counter;
   logic             tc;
   logic             carry;
   logic             ovf;

   modport master (
      output en, up_dn, clear, load, load_val,
      input  counter, tc, carry, ovf
   );

   modport slave (
      input  en, up_dn, clear, load, load_val,
      output counter, tc, carry, ovf
   );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clear, load, wrap or saturate and overflow status.
// Latency: counter/carry/ovf update one cycle after the command; tc is combinational.
// Backpressure: none; one step per clock, all commands accepted every cycle.
module updown_counter_param #(
   parameter int     WIDTH    = 16,
   parameter longint MODULUS  = longint'(1) << WIDTH,
   parameter bit     SATURATE = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   updown_counter_param_if.slave bus
);

   // Refuse to build with a width or modulus outside the supported range.
   generate
      if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_param
         $fatal(1, "updown_counter_param: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   // Range end and modulus, kept one bit wider so MODULUS = 2**WIDTH is representable.
   localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] count_q, count_d;
   logic             carry_q, carry_d;
   logic             ovf_q,   ovf_d;

   logic [WIDTH:0]   count_x;
   logic [WIDTH:0]   up_x;
   logic [WIDTH:0]   dn_x;
   logic [WIDTH:0]   load_x;
   logic             up_end;
   logic             dn_end;

   // Extended arithmetic: reaching MODULUS going up, or borrowing into the
   // extra bit going down, marks the range end without relying on overflow.
   assign count_x = {1'b0, count_q};
   assign up_x    = count_x + 1'b1;
   assign dn_x    = count_x - 1'b1;
   assign load_x  = {1'b0, bus.load_val};
   assign up_end  = (up_x == MOD_X);
   assign dn_end  = dn_x[WIDTH];

   // Terminal count: high in exactly the cycle whose edge wraps or saturates.
   always_comb begin
      bus.tc = bus.en & ~bus.clear & ~bus.load & ~reset & (bus.up_dn ? up_end : dn_end);
   end

   // Next-state selection in priority order clear, load, enable; reset is in the register.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      ovf_d   = ovf_q;
      if (bus.clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (bus.load) begin
         count_d = (load_x > MAX_X) ? MAX : bus.load_val;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (up_end) begin
               count_d = SATURATE ? MAX : '0;
               carry_d = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = up_x[WIDTH-1:0];
            end
         end else begin
            if (dn_end) begin
               count_d = SATURATE ? '0 : MAX;
               carry_d = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               count_d = dn_x[WIDTH-1:0];
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.counter = count_q;
   assign bus.carry   = carry_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for three counter configurations: default 16-bit wrap,
// 4-bit modulo-10 wrap, and 8-bit modulo-200 saturate.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_updown_counter_param;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk;
   logic rst0, rst1, rst2;

   updown_counter_param_if #(.WIDTH(16)) if0 ();
   updown_counter_param_if #(.WIDTH(4))  if1 ();
   updown_counter_param_if #(.WIDTH(8))  if2 ();

   updown_counter_param #(.WIDTH(16)) dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (if0.slave)
   );

   updown_counter_param #(.WIDTH(4), .MODULUS(10)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (if1.slave)
   );

   updown_counter_param #(.WIDTH(8), .MODULUS(200), .SATURATE(1'b1)) dut2 (
      .clk   (clk),
      .reset (rst2),
      .bus   (if2.slave)
   );

   typedef struct {
      int          d;
      logic        tc;
      logic [31:0] cnt;
      logic        carry;
      logic        ovf;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
      end
   endtask

   task automatic idle_all();
      rst0 = L; rst1 = L; rst2 = L;
      if0.en = L; if0.up_dn = H; if0.clear = L; if0.load = L; if0.load_val = '0;
      if1.en = L; if1.up_dn = H; if1.clear = L; if1.load = L; if1.load_val = '0;
      if2.en = L; if2.up_dn = H; if2.clear = L; if2.load = L; if2.load_val = '0;
   endtask

   // One command on DUT d; expectation: tc before the edge, state after it.
   task automatic step(input int d, input logic r, input logic e, input logic u,
                       input logic c, input logic l, input logic [31:0] lv,
                       input logic x_tc, input logic [31:0] x_cnt,
                       input logic x_carry, input logic x_ovf, input string nm);
      exp_t x;
      @(negedge clk);
      idle_all();
      case (d)
         0: begin
            rst0 = r; if0.en = e; if0.up_dn = u; if0.clear = c; if0.load = l; if0.load_val = lv[15:0];
         end
         1: begin
            rst1 = r; if1.en = e; if1.up_dn = u; if1.clear = c; if1.load = l; if1.load_val = lv[3:0];
         end
         default: begin
            rst2 = r; if2.en = e; if2.up_dn = u; if2.clear = c; if2.load = l; if2.load_val = lv[7:0];
         end
      endcase
      x.d = d; x.tc = x_tc; x.cnt = x_cnt; x.carry = x_carry; x.ovf = x_ovf; x.name = nm;
      q.push_back(x);
   endtask

   // Monitor: tc just before the edge, registered outputs just after it.
   initial begin
      exp_t        e;
      logic        a_tc, a_carry, a_ovf;
      logic [31:0] a_cnt;
      forever begin
         @(negedge clk);
         #4;
         if (q.size() != 0) begin
            e = q.pop_front();
            case (e.d)
               0:       a_tc = if0.tc;
               1:       a_tc = if1.tc;
               default: a_tc = if2.tc;
            endcase
            @(posedge clk);
            #1;
            case (e.d)
               0: begin
                  a_cnt = 32'(if0.counter); a_carry = if0.carry; a_ovf = if0.ovf;
               end
               1: begin
                  a_cnt = 32'(if1.counter); a_carry = if1.carry; a_ovf = if1.ovf;
               end
               default: begin
                  a_cnt = 32'(if2.counter); a_carry = if2.carry; a_ovf = if2.ovf;
               end
            endcase
            chk(e.name, "tc",      32'(a_tc),    32'(e.tc));
            chk(e.name, "counter", a_cnt,        e.cnt);
            chk(e.name, "carry",   32'(a_carry), 32'(e.carry));
            chk(e.name, "ovf",     32'(a_ovf),   32'(e.ovf));
         end
      end
   end

   initial begin
      idle_all();

      // ---- DUT0: WIDTH=16, wrap ----
      //    d  rst en up clr ld  load_val   tc cnt      car ovf
      step(0, H, H, H, L, H, 32'h1234, L, 32'h0,    L, L, "d0_rst1");
      step(0, H, H, H, L, H, 32'h1234, L, 32'h0,    L, L, "d0_rst2");
      for (int i = 1; i <= 5; i++)
         step(0, L, H, H, L, L, 32'h0, L, 32'(i), L, L, "d0_up5");
      step(0, L, L, H, L, H, 32'hFFFE, L, 32'hFFFE, L, L, "d0_ld_fffe");
      step(0, L, H, H, L, L, 32'h0,    L, 32'hFFFF, L, L, "d0_to_ffff");
      step(0, L, H, H, L, L, 32'h0,    H, 32'h0000, H, H, "d0_wrap");
      step(0, L, H, H, L, L, 32'h0,    L, 32'h0001, L, H, "d0_after_wrap");
      // priority
      step(0, L, H, H, H, H, 32'h55,   L, 32'h0,    L, L, "d0_clr_ld_en");
      step(0, L, H, H, L, H, 32'd37,   L, 32'd37,   L, L, "d0_ld37_en");
      step(0, L, L, H, L, L, 32'h0,    L, 32'd37,   L, L, "d0_hold");
      step(0, L, L, H, L, H, 32'hFFFF, L, 32'hFFFF, L, L, "d0_ld_ffff");
      step(0, L, H, H, L, L, 32'h0,    H, 32'h0,    H, H, "d0_wrap2");
      step(0, L, L, L, L, L, 32'h0,    L, 32'h0,    L, H, "d0_hold_carry0");
      // reset mid-count
      step(0, L, L, H, L, H, 32'd10,   L, 32'd10,   L, H, "d0_ld10");
      step(0, L, H, H, L, L, 32'h0,    L, 32'd11,   L, H, "d0_to11");
      step(0, L, H, H, L, L, 32'h0,    L, 32'd12,   L, H, "d0_to12");
      step(0, H, H, H, L, L, 32'h0,    L, 32'h0,    L, L, "d0_rst_mid");
      step(0, L, H, H, L, L, 32'h0,    L, 32'd1,    L, L, "d0_resume");

      // ---- DUT1: WIDTH=4, MODULUS=10, wrap ----
      step(1, H, H, L, L, L, 32'h0,    L, 32'h0,    L, L, "d1_rst");
      step(1, L, L, L, L, H, 32'd2,    L, 32'd2,    L, L, "d1_ld2");
      step(1, L, H, L, L, L, 32'h0,    L, 32'd1,    L, L, "d1_dn1");
      step(1, L, H, L, L, L, 32'h0,    L, 32'd0,    L, L, "d1_dn0");
      step(1, L, H, L, L, L, 32'h0,    H, 32'd9,    H, H, "d1_wrap9");
      step(1, L, H, L, L, L, 32'h0,    L, 32'd8,    L, H, "d1_dn8");
      step(1, L, L, L, L, H, 32'd15,   L, 32'd9,    L, H, "d1_ld_clamp");
      step(1, L, H, H, L, L, 32'h0,    H, 32'd0,    H, H, "d1_up_wrap");
      step(1, L, H, L, L, L, 32'h0,    H, 32'd9,    H, H, "d1_dir_change");

      // ---- DUT2: WIDTH=8, MODULUS=200, saturate ----
      step(2, H, L, H, L, L, 32'h0,    L, 32'h0,    L, L, "d2_rst");
      step(2, L, L, H, L, H, 32'd198,  L, 32'd198,  L, L, "d2_ld198");
      step(2, L, H, H, L, L, 32'h0,    L, 32'd199,  L, L, "d2_up199");
      for (int i = 0; i < 3; i++)
         step(2, L, H, H, L, L, 32'h0, H, 32'd199, H, H, "d2_sat_hi");
      step(2, L, L, H, H, L, 32'h0,    L, 32'd0,    L, L, "d2_clear");
      step(2, L, H, L, L, L, 32'h0,    H, 32'd0,    H, H, "d2_sat_lo1");
      step(2, L, H, L, L, L, 32'h0,    H, 32'd0,    H, H, "d2_sat_lo2");
      step(2, L, L, L, L, L, 32'h0,    L, 32'd0,    L, H, "d2_hold");
      step(2, L, L, H, L, H, 32'd250,  L, 32'd199,  L, H, "d2_ld_clamp");

      // Drain the scoreboard, bounded.
      @(negedge clk);
      idle_all();
      for (int k = 0; k < 20 && q.size() != 0; k++)
         @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end else begin
         @(posedge clk);
         #2;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
